// File: rtl/gpu_instr_queue.sv
// Instruction queue for the GPU front end.
// A first-word-fall-through FIFO with an explicit occupancy counter.
// It has a flush, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module gpu_instr_queue #(
  parameter int DATA_W   = 79,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              popAcc;
  logic              pushAcc;

  // Status flags are pure decodes of the registered count.
  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == CNT_W'(DEPTH));
  assign almost_full_o  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty_o = (count_q <= CNT_W'(AE_LEVEL));
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // A pop needs data. A push needs space, or space freed by a pop in the same cycle.
  assign popAcc  = pop_i & ~empty_o & ~flush_i;
  assign pushAcc = push_i & ~flush_i & (~full_o | popAcc);

  // The head entry falls through with no read latency; it reads as zero when the queue is empty.
  assign data_o = empty_o ? '0 : mem_q[rdPtr_q];

  // Next-state pointers, occupancy and sticky error flags; flush wins over push and pop.
  always_comb begin
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (popAcc)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (pushAcc) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pushAcc && !popAcc)      count_d = count_q + CNT_W'(1);
      else if (popAcc && !pushAcc) count_d = count_q - CNT_W'(1);
    end

    if (err_clr_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push_i && !flush_i && !pushAcc) overflow_d  = 1'b1;
    if (pop_i  && !flush_i && !popAcc)  underflow_d = 1'b1;
  end

  // Control state register; reset overrides every other request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is written on accepted pushes only; it is never reset.
  always_ff @(posedge clk) begin
    if (!rst && pushAcc) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: doc/gpu_instr_queue.md
GPU_INSTR_QUEUE -- requirements
Module: gpu_instr_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 79: width of one packed instruction word.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries; a power of two, at least 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full threshold, in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty threshold, in entries.
REQ-005 SHALL derive CNT_W = log2(DEPTH)+1.
REQ-006 clk  in  1: single clock; all state updates on the rising edge.
REQ-007 rst  in  1: reset, synchronous and active-high.
REQ-008 flush_i  in  1: discard all queued entries.
REQ-009 push_i  in  1: write request.
REQ-010 data_i  in  DATA_W: word to push.
REQ-011 pop_i  in  1: read request.
REQ-012 err_clr_i  in  1: clear the sticky error flags.
REQ-013 data_o  out  DATA_W: head entry, first-word-fall-through.
REQ-014 empty_o  out  1: count == 0.
REQ-015 full_o  out  1: count == DEPTH.
REQ-016 almost_full_o  out  1: count >= AF_LEVEL.
REQ-017 almost_empty_o  out  1: count <= AE_LEVEL.
REQ-018 count_o  out  CNT_W: current occupancy, 0..DEPTH.
REQ-019 overflow_o  out  1: sticky flag, set by a rejected push.
REQ-020 underflow_o  out  1: sticky flag, set by a rejected pop.

Function
REQ-021 pop_acc SHALL equal pop_i & !empty_o & !flush_i.
REQ-022 push_acc SHALL equal push_i & !flush_i & (!full_o | pop_acc), so a simultaneous push and pop when full is legal.
REQ-023 On push_acc, data_i SHALL be written to mem[wr_ptr] and wr_ptr SHALL advance by 1, wrapping from DEPTH-1 to 0.
REQ-024 On pop_acc, rd_ptr SHALL advance by 1 with the same wrap rule.
REQ-025 Count SHALL update as follows: +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither occur.
REQ-026 data_o SHALL be combinationally mem[rd_ptr] when not empty, and all-zero when empty (zero read latency).
REQ-027 A pushed word SHALL appear on data_o the cycle after the push if the queue was empty.
REQ-028 Simultaneous push and pop on an empty queue: the pop SHALL be rejected and the push accepted; count becomes 1.
REQ-029 Flush SHALL zero rd_ptr, wr_ptr and count in the next cycle; it takes priority over push and pop in the same cycle; memory contents are untouched.
REQ-030 overflow_o SHALL set on push_i & !flush_i & !push_acc.
REQ-031 underflow_o SHALL set on pop_i & !flush_i & !pop_acc.
REQ-032 The error flags SHALL remain set until err_clr_i is asserted; a set in the same cycle as a clear wins; flush does not affect them.
REQ-033 All flag outputs SHALL be combinational decodes of the registered count.
REQ-034 Occupancy SHALL be tracked with an explicit count register, not inferred from pointer equality.

Reset
REQ-035 While rst=1 at a clock edge, rd_ptr, wr_ptr, count, overflow_o and underflow_o SHALL be cleared to 0; memory need not be reset.
REQ-036 After reset: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, count_o=0, data_o=0.
REQ-037 Reset SHALL take priority over flush, push, pop and err_clr_i, including mid-operation with a full queue.

Verification (DEPTH=8, DATA_W=79, defaults)
REQ-038 Push 0x1..0x8 on consecutive cycles -> count_o=8, full_o=1, almost_full_o=1 from count 6; pops return 0x1..0x8 in order; empty_o=1 after the 8th pop.
REQ-039 Full queue, then push 0x9 with pop_i=1 -> head 0x1 is popped, 0x9 is stored, count stays 8, overflow_o=0; the 9th pop returns 0x9 (wrap-around).
REQ-040 Full queue, push_i=1 with pop_i=0 -> count stays 8, overflow_o=1 and holds until err_clr_i, then reads 0.
REQ-041 Empty queue, push 0xA with pop_i=1 -> underflow_o=1, count_o=1, data_o=0xA next cycle.
REQ-042 Count 5, flush_i=1 with push_i=1 -> count_o=0, empty_o=1, data_o=0 next cycle; a subsequent push 0xB is read back as 0xB.
REQ-043 Count 5, rst=1 for 1 cycle -> all outputs match REQ-036 on the next cycle.
